// File: rtl/sync_debouncer.sv
// Per-bit glitch filter with rise/fall event pulses for already-synchronized slow status lines.
// A new level appears on debounced STABLE_CYCLES enabled samples after it is first seen; no flow control.
module sync_debouncer #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             reset,
    input  logic             clk,
    input  logic [WIDTH-1:0] sync_data,
    input  logic             sample_en,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = (STABLE_CYCLES < 1) ? '0 : CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("sync_debouncer: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] busy_d;

    always_comb begin
        level_d = debounced;
        rise_d  = '0;
        fall_d  = '0;
        busy_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any sample at the stable level restarts qualification, strobe or not.
            if (sync_data[i] == debounced[i]) begin
                cnt_d[i] = '0;
            end else if (sample_en) begin
                if (cnt_q[i] == LAST) begin
                    level_d[i] = sync_data[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = sync_data[i];
                    fall_d[i]  = ~sync_data[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced <= RESET_VALUE;
            rise      <= '0;
            fall      <= '0;
            busy      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            debounced <= level_d;
            rise      <= rise_d;
            fall      <= fall_d;
            busy      <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
- Per-bit glitch filter and edge detector placed directly downstream of ff_synchronizer.
- Consumes the already-synchronized `sync_data` bus. Each bit's debounced output changes only after the input has differed from it for STABLE_CYCLES consecutive enabled samples.
- Emits one-cycle rise/fall event pulses on each debounced transition.
- Used for slow async status lines (e.g. PHY ready, cable-detect) before they reach control FSMs.

Parameters:
- WIDTH, 1: number of independent bits filtered.
- STABLE_CYCLES, 16: consecutive enabled samples required to accept a new level. Must be ≥ 1; 0 is an elaboration-time error.
- RESET_VALUE, 0 (WIDTH bits): reset value of `debounced`. Must match the upstream synchronizer's RESET_VALUE.

Ports:
- reset  input  1  asynchronous, active-high reset
- clk  input  1  clock, same domain as upstream sync_data
- sync_data  input  WIDTH  synchronized input bus
- sample_en  input  1  sample strobe (prescaler tick); tie to 1 for per-clock sampling
- debounced  output  WIDTH  filtered level, registered
- rise  output  WIDTH  one-cycle pulse: debounced bit went 0→1
- fall  output  WIDTH  one-cycle pulse: debounced bit went 1→0
- busy  output  WIDTH  bit's counter is non-zero (candidate change in progress)

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset values: debounced = RESET_VALUE, rise = 0, fall = 0, busy = 0, all counters = 0.
- All outputs are registered; no combinational path from sync_data to any output.
- Per-bit state: stable level s (drives debounced[i]) and counter c, width $clog2(STABLE_CYCLES+1).
- Each clk edge, evaluated in this priority order:
  - sync_data[i] == s → c <= 0. This applies regardless of sample_en, so any return to the stable level, even one cycle long, restarts qualification.
  - sync_data[i] != s and sample_en = 0 → c holds.
  - sync_data[i] != s, sample_en = 1, c < STABLE_CYCLES-1 → c <= c+1.
  - sync_data[i] != s, sample_en = 1, c == STABLE_CYCLES-1 → s <= sync_data[i], c <= 0, and rise[i] or fall[i] <= 1 for exactly that one cycle.
- rise and fall are 0 on every other cycle; rise and fall of the same bit are never asserted together.
- Latency with sample_en = 1 constant: a level first presented before edge k becomes visible on debounced after edge k+STABLE_CYCLES-1, i.e. STABLE_CYCLES clocks after it is first sampled.
- STABLE_CYCLES = 1: debounced is sync_data delayed by one enabled sample; busy is always 0.
- busy[i] = (c != 0), registered with c.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- Bits are fully independent: simultaneous transitions on multiple bits each qualify on their own counter.
- Reset asserted mid-qualification: counters clear and debounced returns to RESET_VALUE immediately (asynchronously), with no rise/fall pulse. After reset release, an input already at non-reset level re-qualifies from c = 0.
- sample_en held low indefinitely: debounced is frozen, but a return to the stable level still clears c.

Test Plan:
- WIDTH=1, STABLE_CYCLES=4, RESET_VALUE=0, sample_en=1. Assert reset with sync_data=1 → debounced=0, rise=0, busy=0 during reset. Release reset → debounced=1 exactly 4 clocks later; rise=1 for that single cycle.
- Same config, sync_data high for 3 cycles then low 1 cycle, repeated 10 times → debounced stays 0, no rise pulse, busy toggles 1/0.
- Same config, sample_en=1 every 3rd clock, sync_data steps 0→1 → debounced rises after the 4th enabled sample (edge 10–12 depending on phase); c holds between strobes.
- WIDTH=2, STABLE_CYCLES=4. bit0 steps 0→1 at t=0; bit1 steps 0→1 at t=2 and 1→0 at t=8 → rise[0] at t=4, rise[1] at t=6, fall[1] at t=12; each pulse lasts one cycle.
- STABLE_CYCLES=4, sync_data=1 held; assert async reset at c=2 (mid-clock) → debounced=0 and busy=0 immediately, no pulse. After release, rise occurs 4 clocks later.
- STABLE_CYCLES=1 → debounced equals sync_data delayed one clock; rise/fall coincide with each change; busy always 0.
